// File: rtl/vx_cache_mem_arbiter_pkg.sv
// Shared helpers for the cache memory arbiter: index-width derivation and the
// outgoing tag layout {requester tag, source index}.
`define VX_MEM_TAG_PACK(tag, idx) {tag, idx}

package vx_cache_mem_arbiter_pkg;

    // Width of an index able to address n entries (never below 1 bit).
    function automatic int unsigned vx_log2_up(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_grant.sv
// Round-robin grant: first asserted request at or after ptr, scanning cyclically.
module vx_rr_grant #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int unsigned j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/vx_cache_mem_arbiter.sv
// Round-robin sharing of one line-wide memory port among cache requesters,
// with credit-limited reads and index-routed responses. Optional: VX_MEM_ARB_PERF_EN.
module vx_cache_mem_arbiter
    import vx_cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned LINE_SIZE    = 64,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned TAG_IN_WIDTH = 8,
    parameter int unsigned MAX_PENDING  = 16,
    localparam int unsigned IDX_W         = vx_log2_up(NUM_INPUTS),
    localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W,
    localparam int unsigned CNT_W         = $clog2(MAX_PENDING + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_INPUTS-1:0]               in_req_valid,
    input  logic [NUM_INPUTS-1:0]               in_req_rw,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]    in_req_addr,
    input  logic [NUM_INPUTS*LINE_SIZE*8-1:0]   in_req_data,
    input  logic [NUM_INPUTS*LINE_SIZE-1:0]     in_req_byteen,
    input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]  in_req_tag,
    output logic [NUM_INPUTS-1:0]               in_req_ready,
    output logic [NUM_INPUTS-1:0]               in_rsp_valid,
    output logic [LINE_SIZE*8-1:0]              in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]             in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]               in_rsp_ready,
    output logic                                out_req_valid,
    output logic                                out_req_rw,
    output logic [ADDR_WIDTH-1:0]               out_req_addr,
    output logic [LINE_SIZE*8-1:0]              out_req_data,
    output logic [LINE_SIZE-1:0]                out_req_byteen,
    output logic [TAG_OUT_WIDTH-1:0]            out_req_tag,
    input  logic                                out_req_ready,
    input  logic                                out_rsp_valid,
    input  logic [LINE_SIZE*8-1:0]              out_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]            out_rsp_tag,
    output logic                                out_rsp_ready
`ifdef VX_MEM_ARB_PERF_EN
    ,
    output logic [31:0]                         perf_credit_stalls,
    output logic [31:0]                         perf_reads
`endif
);

    localparam int unsigned DATA_W = LINE_SIZE * 8;

    logic [CNT_W-1:0]      pending;
    logic [IDX_W-1:0]      rr;
    logic                  stage_load;
    logic                  credit_ok;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      gidx;
    logic                  gvalid;
    logic                  read_acc;
    logic [IDX_W-1:0]      rsp_idx;
    logic                  idx_ok;
    logic                  rsp_fire;

    assign stage_load = !out_req_valid || out_req_ready;
    // Credit check uses the registered count: a response this cycle frees nothing yet.
    assign credit_ok  = (pending < CNT_W'(MAX_PENDING));
    assign eligible   = stage_load ? (in_req_valid & (in_req_rw | {NUM_INPUTS{credit_ok}})) : '0;

    vx_rr_grant #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req         (eligible),
        .ptr         (rr),
        .grant       (grant),
        .grant_idx   (gidx),
        .grant_valid (gvalid)
    );

    assign in_req_ready = reset ? grant : '0;
    assign read_acc     = gvalid && !in_req_rw[gidx];

    assign rsp_idx     = out_rsp_tag[IDX_W-1:0];
    assign idx_ok      = ({1'b0, rsp_idx} < (IDX_W + 1)'(NUM_INPUTS));
    assign in_rsp_data = out_rsp_data;
    assign in_rsp_tag  = out_rsp_tag[TAG_OUT_WIDTH-1:IDX_W];
    assign rsp_fire    = out_rsp_valid && out_rsp_ready;

    // Out-of-range indices are swallowed so a stray response cannot stall the bus.
    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        if (idx_ok) begin
            in_rsp_valid[rsp_idx] = out_rsp_valid;
            out_rsp_ready         = in_rsp_ready[rsp_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_req_valid  <= 1'b0;
            out_req_rw     <= 1'b0;
            out_req_addr   <= '0;
            out_req_data   <= '0;
            out_req_byteen <= '0;
            out_req_tag    <= '0;
            rr             <= '0;
        end else if (gvalid) begin
            out_req_valid  <= 1'b1;
            out_req_rw     <= in_req_rw[gidx];
            out_req_addr   <= in_req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            out_req_data   <= in_req_data[gidx*DATA_W +: DATA_W];
            out_req_byteen <= in_req_byteen[gidx*LINE_SIZE +: LINE_SIZE];
            out_req_tag    <= `VX_MEM_TAG_PACK(in_req_tag[gidx*TAG_IN_WIDTH +: TAG_IN_WIDTH], gidx);
            rr             <= IDX_W'((int'(gidx) + 1) % NUM_INPUTS);
        end else if (out_req_ready) begin
            out_req_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (read_acc && !rsp_fire) begin
            pending <= pending + CNT_W'(1);
        end else if (rsp_fire && !read_acc && (pending != '0)) begin
            pending <= pending - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && rsp_fire) begin
            assert (idx_ok);
            assert (pending != '0);
        end
    end

`ifdef VX_MEM_ARB_PERF_EN
    logic read_any;
    assign read_any = |(in_req_valid & ~in_req_rw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_credit_stalls <= '0;
            perf_reads         <= '0;
        end else begin
            if (read_any && stage_load && (pending == CNT_W'(MAX_PENDING)))
                perf_credit_stalls <= perf_credit_stalls + 32'd1;
            if (read_acc)
                perf_reads <= perf_reads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_cache_mem_arbiter.sv
// Directed bench for vx_cache_mem_arbiter: a reference model predicts grants and
// credits, and a queue holds the request expected at the output stage.
module tb_vx_cache_mem_arbiter;

    localparam int N   = 4;
    localparam int LS  = 4;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int MP  = 5;
    localparam int IW  = 2;
    localparam int TOW = TW + IW;
    localparam int DW  = LS * 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_req_valid, in_req_rw, in_req_ready;
    logic [N*AW-1:0]  in_req_addr;
    logic [N*DW-1:0]  in_req_data;
    logic [N*LS-1:0]  in_req_byteen;
    logic [N*TW-1:0]  in_req_tag;
    logic [N-1:0]     in_rsp_valid, in_rsp_ready;
    logic [DW-1:0]    in_rsp_data;
    logic [TW-1:0]    in_rsp_tag;
    logic             out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]    out_req_addr;
    logic [DW-1:0]    out_req_data;
    logic [LS-1:0]    out_req_byteen;
    logic [TOW-1:0]   out_req_tag;
    logic             out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]    out_rsp_data;
    logic [TOW-1:0]   out_rsp_tag;

    always #5 clk = ~clk;

    vx_cache_mem_arbiter #(
        .NUM_INPUTS   (N),
        .LINE_SIZE    (LS),
        .ADDR_WIDTH   (AW),
        .TAG_IN_WIDTH (TW),
        .MAX_PENDING  (MP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .in_req_rw      (in_req_rw),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_byteen  (in_req_byteen),
        .in_req_tag     (in_req_tag),
        .in_req_ready   (in_req_ready),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .in_rsp_ready   (in_rsp_ready),
        .out_req_valid  (out_req_valid),
        .out_req_rw     (out_req_rw),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_byteen (out_req_byteen),
        .out_req_tag    (out_req_tag),
        .out_req_ready  (out_req_ready),
        .out_rsp_valid  (out_rsp_valid),
        .out_rsp_data   (out_rsp_data),
        .out_rsp_tag    (out_rsp_tag),
        .out_rsp_ready  (out_rsp_ready)
    );

    typedef struct packed {
        logic           rw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [LS-1:0]  be;
        logic [TOW-1:0] tag;
    } pkt_t;

    pkt_t exp_q[$];
    int   m_rr   = 0;
    int   m_pend = 0;
    int   n_err  = 0;
    int   n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic rw);
        in_req_valid[i]           = v;
        in_req_rw[i]              = rw;
        in_req_addr[i*AW +: AW]   = AW'(32'h100 * (i + 1) + 32'h7);
        in_req_data[i*DW +: DW]   = DW'(32'hD0D0_0000 + i * 32'h1111);
        in_req_byteen[i*LS +: LS] = LS'(4'hF - i);
        in_req_tag[i*TW +: TW]    = TW'(8'h30 + i);
    endtask

    // One clock: check combinational outputs and the output stage at the negedge,
    // advance the model, and return #1 after the posedge.
    task automatic cycle();
        logic [N-1:0] elig, exp_rdy, exp_rv;
        logic         exp_ordy, load, fire, rdacc;
        int           g, ridx, j;
        pkt_t         p;
        @(negedge clk);
        chk("out_req_valid", out_req_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("out_req_rw", out_req_rw, exp_q[0].rw);
            chk("out_req_addr", out_req_addr, exp_q[0].addr);
            chk("out_req_data", out_req_data, exp_q[0].data);
            chk("out_req_byteen", out_req_byteen, exp_q[0].be);
            chk("out_req_tag", out_req_tag, exp_q[0].tag);
        end
        chk("pending", dut.pending, m_pend);
        load = (exp_q.size() == 0) || out_req_ready;
        for (int i = 0; i < N; i++)
            elig[i] = in_req_valid[i] && (in_req_rw[i] || (m_pend < MP));
        g = -1;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (g < 0 && elig[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_req_ready", in_req_ready, exp_rdy);
        ridx = int'(out_rsp_tag[IW-1:0]);
        exp_rv = '0;
        exp_rv[ridx] = out_rsp_valid;
        exp_ordy = in_rsp_ready[ridx];
        chk("in_rsp_valid", in_rsp_valid, exp_rv);
        chk("out_rsp_ready", out_rsp_ready, exp_ordy);
        chk("in_rsp_tag", in_rsp_tag, out_rsp_tag[TOW-1:IW]);
        fire  = out_rsp_valid && exp_ordy;
        rdacc = (g >= 0) && !in_req_rw[g];
        if (exp_q.size() > 0 && out_req_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
            p.rw   = in_req_rw[g];
            p.addr = in_req_addr[g*AW +: AW];
            p.data = in_req_data[g*DW +: DW];
            p.be   = in_req_byteen[g*LS +: LS];
            p.tag  = {in_req_tag[g*TW +: TW], IW'(g)};
            exp_q.push_back(p);
            m_rr = (g + 1) % N;
        end
        if (rdacc && !fire) m_pend++;
        else if (fire && !rdacc && m_pend > 0) m_pend--;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        in_req_valid  = '0;
        in_req_rw     = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_byteen = '0;
        in_req_tag    = '0;
        in_rsp_ready  = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        out_rsp_tag   = '0;
        #2;
        chk("rst_out_valid", out_req_valid, 0);
        chk("rst_out_addr", out_req_addr, 0);
        chk("rst_out_tag", out_req_tag, 0);
        chk("rst_in_ready", in_req_ready, 0);
        chk("rst_pending", dut.pending, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Round-robin fairness: all four reading, downstream always ready.
        out_req_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_tag_lsb", out_req_tag[IW-1:0], i % 4);
        end

        // Credits exhausted: a write still wins while the read waits.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0);
        set_req(0, 1'b1, 1'b0);
        set_req(2, 1'b1, 1'b1);
        cycle();
        chk("wr_bypass_rw", out_req_rw, 1);
        chk("wr_bypass_idx", out_req_tag[IW-1:0], 2);
        set_req(2, 1'b0, 1'b0);
        cycle();
        chk("cap_stall", in_req_ready, 4'b0000);

        // Response routing to requester 3, first held off, then accepted.
        out_rsp_valid = 1'b1;
        out_rsp_data  = 32'hCAFE_F00D;
        out_rsp_tag   = {8'hA5, 2'd3};
        #1;
        chk("rsp_valid_route", in_rsp_valid, 4'b1000);
        chk("rsp_tag_strip", in_rsp_tag, 8'hA5);
        chk("rsp_ready_held", out_rsp_ready, 0);
        chk("rsp_data", in_rsp_data, 32'hCAFE_F00D);
        cycle();
        in_rsp_ready = 4'b1000;
        cycle();
        chk("credit_return", dut.pending, MP - 1);
        out_rsp_valid = 1'b0;
        cycle();
        chk("cap_release_idx", out_req_tag[IW-1:0], 0);
        chk("cap_release_valid", out_req_valid, 1);
        set_req(0, 1'b0, 1'b0);

        // Drain all credits through every response index.
        in_rsp_ready  = '1;
        out_rsp_valid = 1'b1;
        for (int i = 0; i < MP; i++) begin
            out_rsp_tag = {TW'(8'h50 + i), IW'(i % N)};
            cycle();
        end
        out_rsp_valid = 1'b0;
        chk("drained", dut.pending, 0);

        // Backpressure: request held for five cycles, then two more granted.
        out_req_ready = 1'b0;
        set_req(1, 1'b1, 1'b0);
        set_req(3, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        out_req_ready = 1'b1;
        cycle();
        chk("bp_resume_idx", out_req_tag[IW-1:0], 3);
        cycle();
        chk("bp_next_idx", out_req_tag[IW-1:0], 1);
        set_req(3, 1'b0, 1'b0);
        for (int k = 0; k < 10 && m_pend < MP; k++) cycle();
        chk("refill_pending", dut.pending, MP);

        // Async reset with a held write and a full credit counter.
        set_req(1, 1'b0, 1'b0);
        cycle();
        out_req_ready = 1'b0;
        set_req(2, 1'b1, 1'b1);
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", out_req_valid, 0);
        chk("async_pending", dut.pending, 0);
        chk("async_in_ready", in_req_ready, 0);
        chk("async_out_addr", out_req_addr, 0);
        exp_q.delete();
        m_pend = 0;
        m_rr   = 0;
        set_req(2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_req_ready = 1'b1;
        set_req(3, 1'b1, 1'b0);
        cycle();
        chk("post_reset_idx", out_req_tag[IW-1:0], 3);
        set_req(3, 1'b0, 1'b0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
